// File: rtl/clk_ctrl_pkg.sv
// Shared constants and helpers for the clock-switch controller and its arbiter.
package clk_ctrl_pkg;

    // FSM state encoding, kept as plain constants for legacy tool flows.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_GRANT  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    // Default timing for a typical clk_switch handover.
    localparam int DEF_SETTLE_CYC = 8;
    localparam int DEF_HOLD_CYC   = 16;

    // Bits needed to hold a requester index / round-robin pointer (0..n-1).
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Bits needed for a down-counter that is loaded with (max(a,b) - 1).
    function automatic int tmr_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping around. Produces a one-hot grant plus the granted index.
module rr_arbiter
    import clk_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Scan NREQ positions starting at the pointer; the first hit wins.
    always_comb begin
        int j;
        j       = 0;
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(i_ptr) + k) % NREQ;
            if (!o_valid && i_req[j]) begin
                o_valid  = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDX_W'(j);
            end else begin
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/clk_switch_ctrl.sv
// Arbitration and sequencing controller for the glitch-free clock mux.
// Serves one requester at a time: grant, optional select toggle, settle
// window, acknowledge, and a hold-off after a real switch to avoid chatter.
module clk_switch_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter bit RST_SEL    = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  req_sel_clk1,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  ack,
    output logic             sel_clk1,
    output logic             busy,
    output logic [CNT_W-1:0] switch_cnt
);

    localparam int IDX_W = idx_width(NREQ);
    localparam int TMR_W = tmr_width(SETTLE_CYC, HOLD_CYC);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'((HOLD_CYC > 0) ? (HOLD_CYC - 1) : 0);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NREQ - 1);

    logic [2:0]       r_state;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_ack;
    logic             r_sel;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_idx;
    logic             r_toggled;
    logic [TMR_W-1:0] r_tmr;

    logic [NREQ-1:0]  w_arb_gnt;
    logic [IDX_W-1:0] w_arb_idx;
    logic             w_arb_valid;
    logic             w_tgt;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    // Target clock of the requester currently being served.
    assign w_tgt = req_sel_clk1[r_idx];

    // Service FSM with select register, settle/hold timer and switch counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_ack     <= '0;
            r_sel     <= RST_SEL;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_toggled <= 1'b0;
            r_tmr     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= '0;
                    if (w_arb_valid) begin
                        r_gnt     <= w_arb_gnt;
                        r_idx     <= w_arb_idx;
                        r_toggled <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_GRANT;
                    end else begin
                        r_gnt  <= '0;
                        r_busy <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (w_tgt == r_sel) begin
                        r_ack   <= r_gnt;
                        r_state <= ST_DONE;
                    end else begin
                        r_sel     <= ~r_sel;
                        r_toggled <= 1'b1;
                        if (r_cnt != {CNT_W{1'b1}}) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end else begin
                            r_cnt <= r_cnt;
                        end
                        r_tmr   <= SETTLE_LOAD;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_tmr == '0) begin
                        r_ack   <= r_gnt;
                        r_state <= ST_DONE;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end
                ST_DONE: begin
                    r_ack <= '0;
                    r_gnt <= '0;
                    r_ptr <= (r_idx == LAST_IDX) ? '0 : (r_idx + IDX_W'(1));
                    if (r_toggled && (HOLD_CYC > 0)) begin
                        r_tmr   <= HOLD_LOAD;
                        r_state <= ST_HOLD;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (r_tmr == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign ack        = r_ack;
    assign sel_clk1   = r_sel;
    assign busy       = r_busy;
    assign switch_cnt = r_cnt;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Scoreboard bench for clk_switch_ctrl: stimulus pushes expected ack records,
// per-DUT monitors pop and compare whenever an ack pulse appears.
module tb_clk_switch_ctrl;

    typedef struct {
        int idx;
        int sel;
        int cnt;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic [3:0]  req, req_sel;
    logic [3:0]  gnt, ack;
    logic        sel_clk1, busy;
    logic [15:0] switch_cnt;

    logic [1:0]  req2, req_sel2;
    logic [1:0]  gnt2, ack2;
    logic        sel2, busy2;
    logic [1:0]  cnt2;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t q1[$];
    exp_t q2[$];

    clk_switch_ctrl #(.NREQ(4), .SETTLE_CYC(8), .HOLD_CYC(16), .RST_SEL(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_sel_clk1(req_sel), .gnt(gnt), .ack(ack),
        .sel_clk1(sel_clk1), .busy(busy), .switch_cnt(switch_cnt));

    clk_switch_ctrl #(.NREQ(2), .SETTLE_CYC(2), .HOLD_CYC(0), .RST_SEL(1'b1), .CNT_W(2)) dut2 (
        .clk(clk), .rstn(rstn), .req(req2), .req_sel_clk1(req_sel2), .gnt(gnt2), .ack(ack2),
        .sel_clk1(sel2), .busy(busy2), .switch_cnt(cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the main DUT: every ack pulse must match the next expected record.
    always @(negedge clk) begin
        if (ack != 4'd0) begin
            if (q1.size() == 0) begin
                chk("m1_unexpected_ack", int'(ack), 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("m1_ack_vec", int'(ack), 1 << e.idx);
                chk("m1_gnt_vec", int'(gnt), 1 << e.idx);
                chk("m1_sel", int'(sel_clk1), e.sel);
                chk("m1_cnt", int'(switch_cnt), e.cnt);
            end
        end
    end

    // Monitor for the narrow-counter DUT.
    always @(negedge clk) begin
        if (ack2 != 2'd0) begin
            if (q2.size() == 0) begin
                chk("m2_unexpected_ack", int'(ack2), 0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("m2_ack_vec", int'(ack2), 1 << e.idx);
                chk("m2_sel", int'(sel2), e.sel);
                chk("m2_cnt", int'(cnt2), e.cnt);
            end
        end
    end

    task automatic wait_gnt(input int i, output int c);
        c = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (gnt[i]) begin c = cyc; return; end
        end
        chk("gnt_timeout", 0, 1);
    endtask

    task automatic wait_ack(input int i, output int c);
        c = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (ack[i]) begin c = cyc; return; end
        end
        chk("ack_timeout", 0, 1);
    endtask

    task automatic wait_ack2(input int i, output int c);
        c = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (ack2[i]) begin c = cyc; return; end
        end
        chk("ack2_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk("idle_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #6 rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n, g, a, c, gi;
        int ga[4];
        int aa[4];
        int tgt;
        rstn = 1'b0; req = 4'd0; req_sel = 4'b1111; req2 = 2'd0; req_sel2 = 2'b11;

        // 1: reset values
        #11 rstn = 1'b1;
        @(negedge clk);
        chk("t1_sel", int'(sel_clk1), 1);
        chk("t1_gnt", int'(gnt), 0);
        chk("t1_ack", int'(ack), 0);
        chk("t1_busy", int'(busy), 0);
        chk("t1_cnt", int'(switch_cnt), 0);

        // 2: no-switch service, then held req re-arbitrated as second no-switch service
        @(posedge clk); #1;
        n = cyc;
        req_sel[0] = 1'b1; req[0] = 1'b1;
        q1.push_back('{0, 1, 0});
        q1.push_back('{0, 1, 0});
        wait_gnt(0, g);  chk("t2_gnt_lat", g - n, 1);
        wait_ack(0, a);  chk("t2_ack_lat", a - n, 2);
        wait_ack(0, a);  chk("t2_ack2_lat", a - n, 5);
        req[0] = 1'b0;
        chk("t2_sel", int'(sel_clk1), 1);

        // 3: switch to clk2, req dropped right after grant, then hold window
        wait_idle();
        @(posedge clk); #1;
        n = cyc;
        req_sel[2] = 1'b0; req[2] = 1'b1;
        q1.push_back('{2, 0, 1});
        wait_gnt(2, g);  chk("t3_gnt_lat", g - n, 1);
        chk("t3_sel_before", int'(sel_clk1), 1);
        req[2] = 1'b0;
        @(negedge clk);  chk("t3_sel_fall", int'(sel_clk1), 0);
        wait_ack(2, a);  chk("t3_ack_lat", a - n, 10);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 1)  chk("t3_hold_gnt", int'(gnt), 0);
            if (k == 16) chk("t3_hold_busy", int'(busy), 1);
            if (k == 17) chk("t3_idle_busy", int'(busy), 0);
        end

        // 4: all four request, alternating targets, fresh pointer
        do_reset();
        chk("t4_rst_sel", int'(sel_clk1), 1);
        chk("t4_rst_cnt", int'(switch_cnt), 0);
        @(posedge clk); #1;
        req_sel = 4'b1010; req = 4'b1111;
        q1.push_back('{0, 0, 1});
        q1.push_back('{1, 1, 2});
        q1.push_back('{2, 0, 3});
        q1.push_back('{3, 1, 4});
        for (int k = 0; k < 4; k++) begin
            gi = -1; ga[k] = -1;
            for (int w = 0; w < 300 && ga[k] < 0; w++) begin
                @(negedge clk);
                if (gnt != 4'd0) begin
                    ga[k] = cyc;
                    for (int j = 0; j < 4; j++) if (gnt[j]) gi = j;
                end
            end
            chk("t4_order", gi, k);
            wait_ack(k, aa[k]);
            req[k] = 1'b0;
            chk("t4_service_len", aa[k] - ga[k], 9);
            if (k > 0) chk("t4_hold_gap", ga[k] - aa[k-1], 18);
        end

        // 5: reset in the middle of settle
        wait_idle();
        do_reset();
        @(posedge clk); #1;
        req_sel[1] = 1'b0; req[1] = 1'b1;
        wait_gnt(1, g);
        @(negedge clk);  chk("t5_sel_settle", int'(sel_clk1), 0);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("t5_sel_async", int'(sel_clk1), 1);
        chk("t5_gnt_async", int'(gnt), 0);
        chk("t5_busy_async", int'(busy), 0);
        chk("t5_cnt_async", int'(switch_cnt), 0);
        req[1] = 1'b0;
        @(posedge clk);
        #6 rstn = 1'b1;
        repeat (12) @(negedge clk);
        chk("t5_busy_after", int'(busy), 0);
        chk("t5_cnt_after", int'(switch_cnt), 0);
        chk("t5_sel_after", int'(sel_clk1), 1);

        // 6: narrow counter saturates after three toggles
        for (int k = 0; k < 5; k++) begin
            tgt = (k % 2 == 0) ? 0 : 1;
            @(posedge clk); #1;
            n = cyc;
            req_sel2[0] = tgt[0]; req2[0] = 1'b1;
            q2.push_back('{0, tgt, (k + 1 > 3) ? 3 : k + 1});
            wait_ack2(0, c);
            req2[0] = 1'b0;
            chk("t6_ack_lat", c - n, 4);
        end

        repeat (3) @(negedge clk);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
Arbitration and sequencing controller for the glitch-free clock mux clk_switch. Several requesters ask for a target clock source. The block round-robin arbitrates between them and drives sel_clk1 into clk_switch. It then holds off for a fixed settle window so the mux completes its handover, and acknowledges the requester. A minimum hold interval between actual switches prevents select chatter. Runs on an always-on reference clock, independent of clk1/clk2.

Parameters:
NREQ, 4, number of requesters (2..8)
SETTLE_CYC, 8, clk cycles sel_clk1 is held stable after a change before ack (>=1)
HOLD_CYC, 16, clk cycles after a completed switch before the next grant (>=0)
RST_SEL, 1, reset value of sel_clk1 (1 = clk1 selected)
CNT_W, 16, width of switch counter

Ports:
clk  in  1  always-on controller clock
rstn  in  1  asynchronous active-low reset
req  in  NREQ  per-requester level request, held until ack
req_sel_clk1  in  NREQ  per-requester target (1 = clk1, 0 = clk2), stable while req high
gnt  out  NREQ  one-hot, high from grant through ack cycle of the requester being served
ack  out  NREQ  one-cycle pulse, request complete
sel_clk1  out  1  registered select to clk_switch.sel_clk1
busy  out  1  high in any state other than IDLE
switch_cnt  out  CNT_W  number of sel_clk1 toggles since reset, saturating

Behaviour:
Interface:
- One clock, clk.
- Reset rstn is asynchronous and active-low.
- All outputs are registered.

Reset values:
- gnt=0, ack=0, busy=0, switch_cnt=0, sel_clk1=RST_SEL.
- State=IDLE; round-robin pointer=0; counters=0.

FSM states: IDLE, GRANT, SETTLE, DONE, HOLD.
- IDLE:
  - If any req is set, pick the first set bit at or after rr_ptr (wrapping).
  - gnt[i] goes high next cycle; move to GRANT.
  - If no req, stay in IDLE.
- GRANT (1 cycle):
  - If req_sel_clk1[i]==sel_clk1, no switch is needed; go to DONE.
  - Otherwise toggle sel_clk1 on the transition edge, increment switch_cnt (saturating at all-ones), load the settle counter, and go to SETTLE.
- SETTLE:
  - Lasts exactly SETTLE_CYC cycles.
  - sel_clk1 is frozen; requests are not evaluated. Then go to DONE.
- DONE (1 cycle):
  - ack[i]=1 and gnt[i] stays 1.
  - rr_ptr <= (i+1) mod NREQ.
  - Next state is HOLD if a toggle happened in this service and HOLD_CYC>0; otherwise IDLE.
- HOLD:
  - Lasts HOLD_CYC cycles with gnt=0. Then go to IDLE.

Latency (req sampled high in IDLE at cycle t):
- gnt at t+1.
- No-switch case: ack at t+2.
- Switch case: sel_clk1 changes at t+2, ack at t+2+SETTLE_CYC.

Boundary cases:
- req[i] dropped mid-service: the service still completes, including sel change, settle and ack. Requesters must not rely on abort.
- Multiple simultaneous reqs: one is granted per service; the others wait; round-robin guarantees no starvation.
- A requester holding req high after ack is re-arbitrated normally. Its next service is a no-switch ack unless another requester changed the select meanwhile.
- rstn asserted mid-service: immediate return to reset values. sel_clk1 snaps to RST_SEL asynchronously and ack is never issued. clk_switch itself tolerates this because its own reset gates the output.
- switch_cnt saturates and does not wrap.
- SETTLE_CYC must cover the worst-case clk_switch handover: two synchronizer stages on each of the slower source clock, converted to clk cycles. The integrator sets it; the block does not check it.

Decomposition:
- Shared package clk_ctrl_pkg holds:
  - FSM state encoding localparams (IDLE=0, GRANT=1, SETTLE=2, DONE=3, HOLD=4);
  - the helper function for next-set-bit-from-pointer width;
  - default SETTLE_CYC/HOLD_CYC constants.
- One natural sub-module, rr_arbiter: a combinational round-robin pick of one-hot grant from req and rr_ptr, reusable elsewhere.
- The FSM, counters and sel register stay in clk_switch_ctrl.

Test Plan:
1. Reset with RST_SEL=1, release rstn at 11 ns. Then sel_clk1=1, all outputs 0, busy=0.
2. req[0]=1 with req_sel_clk1[0]=1 (already selected) -> gnt[0] at t+1, ack[0] at t+2. sel_clk1 stays 1 and switch_cnt stays 0.
3. req[2]=1 with target 0, SETTLE_CYC=8 -> sel_clk1 falls at t+2 and ack[2] at t+10. switch_cnt=1, busy high for HOLD_CYC=16 further cycles. Connected clk_switch output shows no pulse under 2.5 ns.
4. req=4'b1111 with alternating targets, rr_ptr=0 -> grants in order 0,1,2,3, with a HOLD gap after each toggle. Each ack pulses exactly once; no requester is granted twice before the others.
5. Assert rstn low during SETTLE -> sel_clk1 returns to 1 asynchronously. No ack; FSM in IDLE after release; switch_cnt=0.
6. CNT_W=2, five toggling services -> switch_cnt reads 1,2,3,3,3 (saturates).
